// File: rtl/vuart_tx_sched.sv
// vuart_tx_sched: round-robin byte scheduler that polls VUART STAT over APB and
// pushes each granted byte into the VUART TX FIFO.
module vuart_tx_sched #(
  parameter int          N_REQ             = 2,
  parameter logic [15:0] ADDR_STAT         = 16'h0000,
  parameter logic [15:0] ADDR_FIFO         = 16'h0008,
  parameter int          STAT_TXRDY_BIT    = 1,
  parameter int          STAT_HOSTCONN_BIT = 2,
  parameter int          POLL_GAP          = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_drop_no_host,
  input  logic               i_err_clr,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_busy,
  output logic               o_err,
  output logic               o_drop,
  output logic               o_m_psel,
  output logic               o_m_penable,
  output logic               o_m_pwrite,
  output logic [15:0]        o_m_paddr,
  output logic [31:0]        o_m_pwdata,
  input  logic [31:0]        i_m_prdata,
  input  logic               i_m_pready,
  input  logic               i_m_pslverr
);
  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(POLL_GAP + 1);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_ACCESS, GAP, WR_SETUP, WR_ACCESS} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_rr_ptr, w_win;
  logic [7:0] r_byte;
  logic [GW-1:0] r_gap;
  logic r_err, r_drop;
  logic w_any, w_grant, w_err_set, w_drop_set, w_gap_load, w_rd, w_wr, w_unused;
  int w_dist, w_best;
  // Winner is the valid requester with the smallest distance past rr_ptr.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_best = N_REQ;
    w_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i + 2 * N_REQ - 1 - int'(r_rr_ptr)) % N_REQ;
      if (i_req_valid[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_win = IW'(i);
        w_any = 1'b1;
      end
    end
  end
  assign w_grant = (r_state == IDLE) && i_en && w_any && i_rst_n;
  assign o_req_ready = w_grant ? (N_REQ'(1) << w_win) : '0;
  always_comb begin
    w_next = r_state;
    w_err_set = 1'b0;
    w_drop_set = 1'b0;
    w_gap_load = 1'b0;
    case (r_state)
      IDLE:      w_next = w_grant ? RD_SETUP : IDLE;
      RD_SETUP:  w_next = RD_ACCESS;
      RD_ACCESS: if (i_m_pready) begin
        if (i_m_pslverr) begin
          w_err_set = 1'b1;
          w_drop_set = 1'b1;
          w_next = IDLE;
        end else if (i_drop_no_host && !i_m_prdata[STAT_HOSTCONN_BIT]) begin
          w_drop_set = 1'b1;
          w_next = IDLE;
        end else if (i_m_prdata[STAT_TXRDY_BIT]) begin
          w_next = WR_SETUP;
        end else begin
          w_gap_load = 1'b1;
          w_next = GAP;
        end
      end
      GAP:       w_next = (r_gap == '0) ? RD_SETUP : GAP;
      WR_SETUP:  w_next = WR_ACCESS;
      WR_ACCESS: if (i_m_pready) begin
        w_err_set = i_m_pslverr;
        w_drop_set = i_m_pslverr;
        w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_rr_ptr <= IW'(N_REQ - 1);
      r_byte <= '0;
      r_gap <= '0;
      r_err <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err <= w_err_set | (r_err & ~i_err_clr);
      r_drop <= w_drop_set;
      if (w_grant) begin
        r_rr_ptr <= w_win;
        r_byte <= 8'(i_req_data >> {w_win, 3'b000});
      end
      if (w_gap_load) r_gap <= GW'(POLL_GAP - 1);
      else if (r_state == GAP) r_gap <= r_gap - GW'(1);
    end
  end
  // APB controls decode straight from state, so they hold steady across SETUP/ACCESS.
  assign w_rd = (r_state == RD_SETUP) || (r_state == RD_ACCESS);
  assign w_wr = (r_state == WR_SETUP) || (r_state == WR_ACCESS);
  assign o_m_psel = w_rd | w_wr;
  assign o_m_penable = (r_state == RD_ACCESS) || (r_state == WR_ACCESS);
  assign o_m_pwrite = w_wr;
  assign o_m_paddr = w_wr ? ADDR_FIFO : w_rd ? ADDR_STAT : '0;
  assign o_m_pwdata = w_wr ? {24'h0, r_byte} : '0;
  assign o_busy = r_state != IDLE;
  assign o_err = r_err;
  assign o_drop = r_drop;
  assign w_unused = ^i_m_prdata;
endmodule

// File: tb/tb_vuart_tx_sched.sv
// tb_vuart_tx_sched: randomized requesters and APB slave with a transaction-level
// scoreboard for grant order, written bytes, drops, err and poll spacing.
module tb_vuart_tx_sched;
  localparam int N = 3;
  localparam int PG = 4;
  localparam int SRC_MAX = 512;
  localparam logic [15:0] A_STAT = 16'h0000;
  localparam logic [15:0] A_FIFO = 16'h0008;
  logic clk = 0, rst_n = 0, en = 0, dnh = 0, err_clr = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic busy, err, drop, psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata = '0;
  logic pready = 0, pslverr = 0;
  always #5 clk = ~clk;
  vuart_tx_sched #(.N_REQ(N), .ADDR_STAT(A_STAT), .ADDR_FIFO(A_FIFO),
                   .STAT_TXRDY_BIT(1), .STAT_HOSTCONN_BIT(2), .POLL_GAP(PG)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_drop_no_host(dnh), .i_err_clr(err_clr),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .o_busy(busy), .o_err(err), .o_drop(drop),
    .o_m_psel(psel), .o_m_penable(penable), .o_m_pwrite(pwrite), .o_m_paddr(paddr),
    .o_m_pwdata(pwdata), .i_m_prdata(prdata), .i_m_pready(pready), .i_m_pslverr(pslverr));
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask
  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction
  // Requester byte streams and the scoreboard of granted bytes.
  logic [7:0] src [N][SRC_MAX];
  int head [N], tail [N];
  logic [7:0] exp_q [$];
  int p_valid = 100;
  task automatic push(input int i, input logic [7:0] b);
    if (tail[i] < SRC_MAX) begin
      src[i][tail[i]] = b;
      tail[i]++;
    end
  endtask
  initial for (int i = 0; i < N; i++) begin
    head[i] = 0;
    tail[i] = 0;
  end
  initial begin : req_drv
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          exp_q.push_back(src[i][head[i]]);
          head[i]++;
        end
        req_valid[i] = (head[i] != tail[i]) && pct(p_valid);
        if (head[i] != tail[i]) req_data[8*i +: 8] = src[i][head[i]];
      end
    end
  end
  // APB slave with configurable wait states and STAT/error responses.
  int p_txrdy = 100, p_host = 100, p_err = 0, wmin = 0, wmax = 0, fail_polls = 0;
  bit err_wr_once = 0;
  initial begin : slave
    bit in_acc, txr;
    int wleft;
    in_acc = 0;
    wleft = 0;
    forever begin
      @(posedge clk);
      #1;
      if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1;
          wleft = $urandom_range(wmax, wmin);
        end else if (wleft > 0) wleft--;
        pready = (wleft == 0);
        if (pready) begin
          if (!pwrite && fail_polls > 0) begin
            txr = 0;
            fail_polls--;
          end else txr = pct(p_txrdy);
          prdata = $urandom;
          prdata[1] = txr;
          prdata[2] = pct(p_host);
          pslverr = (pwrite && err_wr_once) || pct(p_err);
          if (pwrite) err_wr_once = 0;
        end else begin
          prdata = $urandom;
          pslverr = 1'($urandom);
        end
      end else begin
        in_acc = 0;
        pready = 0;
        pslverr = 0;
      end
    end
  end
  // Monitor: transaction-level model of grants, outcomes, err and drop.
  int n_stat = 0, n_wr = 0, n_drop = 0;
  initial begin : monitor
    logic [N-1:0] exp_rdy;
    logic [15:0] s_addr;
    logic s_wr;
    logic [31:0] s_wd;
    int rr_m, cyc, fail_cyc, j;
    bit infl, drop_m, err_m, gap_pend, dset, eset;
    rr_m = N - 1;
    cyc = 0;
    fail_cyc = 0;
    infl = 0;
    drop_m = 0;
    err_m = 0;
    gap_pend = 0;
    s_addr = '0;
    s_wr = 0;
    s_wd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rr_m = N - 1;
        infl = 0;
        drop_m = 0;
        err_m = 0;
        gap_pend = 0;
        exp_q.delete();
      end else begin
        exp_rdy = '0;
        if (en && !infl) begin
          for (int k = 1; k <= N; k++) begin
            j = (rr_m + k) % N;
            if (req_valid[j]) begin
              exp_rdy[j] = 1'b1;
              rr_m = j;
              break;
            end
          end
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, infl);
        chk("drop", drop, drop_m);
        chk("err", err, err_m);
        if (|exp_rdy) infl = 1;
        dset = 0;
        eset = 0;
        if (psel && !penable) begin
          s_addr = paddr;
          s_wr = pwrite;
          s_wd = pwdata;
          chk("setup_addr", paddr, pwrite ? A_FIFO : A_STAT);
          if (!pwrite) begin
            n_stat++;
            if (gap_pend) chk("poll_gap", cyc - fail_cyc, PG + 1);
            gap_pend = 0;
          end
        end
        if (psel && penable) begin
          chk("access_stable", {paddr, pwrite, pwdata}, {s_addr, s_wr, s_wd});
          if (pready && !pwrite) begin
            if (pslverr) begin
              eset = 1;
              dset = 1;
            end else if (dnh && !prdata[2]) dset = 1;
            else if (!prdata[1]) begin
              gap_pend = 1;
              fail_cyc = cyc;
            end
            if (dset) begin
              infl = 0;
              if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
          end else if (pready) begin
            n_wr++;
            infl = 0;
            if (exp_q.size() == 0) timeout("write_without_grant");
            else chk("write_data", pwdata, {24'h0, exp_q.pop_front()});
            eset = pslverr;
            dset = pslverr;
          end
        end
        if (dset) n_drop++;
        drop_m = dset;
        err_m = eset | (err_m & !err_clr);
      end
    end
  end
  function automatic bit drained();
    bit d;
    d = !busy && exp_q.size() == 0;
    for (int i = 0; i < N; i++) d = d && head[i] == tail[i];
    return d;
  endfunction
  task automatic wait_idle(input string name, input int lim);
    int t;
    t = 0;
    while (!drained() && t < lim) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!drained()) timeout(name);
  endtask
  initial begin : stim
    int s0, w0, d0, bc, seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1;
    en = 1;
    s0 = n_stat;
    w0 = n_wr;
    push(0, 8'h41);
    bc = 0;
    while (!busy && bc < 50) begin
      @(posedge clk);
      #1;
      bc++;
    end
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(posedge clk);
      #1;
    end
    chk("single_busy_cycles", bc, 4);
    chk("single_stat_reads", n_stat - s0, 1);
    chk("single_writes", n_wr - w0, 1);
    for (int k = 0; k < 3; k++) begin
      push(0, 8'h10 + 8'(k));
      push(1, 8'h20 + 8'(k));
    end
    wait_idle("round_robin", 300);
    s0 = n_stat;
    w0 = n_wr;
    fail_polls = 3;
    push(2, 8'h5a);
    wait_idle("full_fifo", 300);
    chk("fullfifo_stat_reads", n_stat - s0, 4);
    chk("fullfifo_writes", n_wr - w0, 1);
    dnh = 1;
    p_host = 0;
    d0 = n_drop;
    w0 = n_wr;
    push(0, 8'h77);
    wait_idle("no_host", 100);
    chk("nohost_drops", n_drop - d0, 1);
    chk("nohost_writes", n_wr - w0, 0);
    dnh = 0;
    d0 = n_drop;
    w0 = n_wr;
    push(0, 8'h78);
    wait_idle("host_ignored", 100);
    chk("hostignored_drops", n_drop - d0, 0);
    chk("hostignored_writes", n_wr - w0, 1);
    p_host = 100;
    wmin = 2;
    wmax = 2;
    err_wr_once = 1;
    d0 = n_drop;
    push(1, 8'h99);
    wait_idle("slverr", 100);
    chk("slverr_err", err, 1);
    chk("slverr_drops", n_drop - d0, 1);
    w0 = n_wr;
    push(1, 8'h9a);
    wait_idle("after_slverr", 100);
    chk("after_slverr_writes", n_wr - w0, 1);
    chk("err_sticky", err, 1);
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    chk("err_cleared", err, 0);
    p_valid = 70;
    p_txrdy = 70;
    p_host = 85;
    p_err = 5;
    wmin = 0;
    wmax = 2;
    repeat (1500) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (pct(6)) push(i, 8'($urandom));
      en = pct(90);
      dnh = pct(30);
      err_clr = pct(3);
    end
    en = 1;
    err_clr = 0;
    p_valid = 100;
    wait_idle("random_drain", 6000);
    p_err = 0;
    p_txrdy = 100;
    p_host = 100;
    wmin = 1;
    wmax = 1;
    for (int i = 0; i < N; i++) begin
      push(i, 8'hc0 + 8'(i));
      push(i, 8'hd0 + 8'(i));
    end
    bc = 0;
    while (!(psel && penable && pwrite) && bc < 100) begin
      @(posedge clk);
      #1;
      bc++;
    end
    if (!(psel && penable && pwrite)) timeout("reach_wr_access");
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;
    wait_idle("after_reset", 300);
    en = 0;
    push(0, 8'h55);
    push(1, 8'h66);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (req_ready != 0) seen++;
    end
    chk("en0_no_ready", seen, 0);
    en = 1;
    wait_idle("en_restore", 200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
